// File: rtl/decode_stage_module_if.sv
// decode_stage_module_if: fetch-side inputs, writeback port and ID/EX outputs of the decode stage.
// Revision: 1.0
`default_nettype none

interface decode_stage_module_if #(
  parameter int XLEN = 32
);
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            RegWriteW;
  logic [4:0]      RDW;
  logic [XLEN-1:0] ResultW;

  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic [2:0]      ALUControlE;
  logic            ALUSrcE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [4:0]      RDE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW,
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
           ALUSrcE, RD1E, RD2E, ImmExtE, RDE, PCE, PCPlus4E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW,
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
           ALUSrcE, RD1E, RD2E, ImmExtE, RDE, PCE, PCPlus4E
  );
endinterface

`default_nettype wire

// File: rtl/decode_stage_module.sv
// decode_stage_module: RV32I-subset decode, 32x32 register file with write-through, ID/EX registers.
// Revision: 1.0
`default_nettype none

module decode_stage_module #(
  parameter int REG_COUNT = 32,
  parameter int XLEN      = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  decode_stage_module_if.slave bus
);
  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_SLT = 3'b101;

  logic [XLEN-1:0] r_rf [REG_COUNT];

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [2:0]      w_alu_f3;
  logic            w_wb_en;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  logic            w_reg_write;
  logic [1:0]      w_result_src;
  logic            w_mem_write;
  logic            w_jump;
  logic            w_branch;
  logic [2:0]      w_alu_ctl;
  logic            w_alu_src;
  logic [XLEN-1:0] w_imm;

  assign w_opcode = bus.InstrD[6:0];
  assign w_funct3 = bus.InstrD[14:12];
  assign w_rs1    = bus.InstrD[19:15];
  assign w_rs2    = bus.InstrD[24:20];

  assign w_imm_i = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:20]};
  assign w_imm_s = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
  assign w_imm_b = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                    bus.InstrD[11:8], 1'b0};
  assign w_imm_j = {{(XLEN-20){bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                    bus.InstrD[30:21], 1'b0};

  always_comb begin
    w_alu_f3 = c_ALU_ADD;
    case (w_funct3)
      3'b111:  w_alu_f3 = c_ALU_AND;
      3'b110:  w_alu_f3 = c_ALU_OR;
      3'b010:  w_alu_f3 = c_ALU_SLT;
      default: w_alu_f3 = c_ALU_ADD;
    endcase
  end

  always_comb begin
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_mem_write  = 1'b0;
    w_jump       = 1'b0;
    w_branch     = 1'b0;
    w_alu_ctl    = c_ALU_ADD;
    w_alu_src    = 1'b0;
    w_imm        = '0;
    case (w_opcode)
      c_OP_LW: begin
        w_reg_write  = 1'b1;
        w_result_src = 2'b01;
        w_alu_src    = 1'b1;
        w_imm        = w_imm_i;
      end
      c_OP_SW: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_s;
      end
      c_OP_R: begin
        w_reg_write = 1'b1;
        w_alu_ctl   = (w_funct3 == 3'b000 && bus.InstrD[30]) ? c_ALU_SUB : w_alu_f3;
      end
      c_OP_I: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_i;
        w_alu_ctl   = w_alu_f3;
      end
      c_OP_BEQ: begin
        w_branch  = 1'b1;
        w_imm     = w_imm_b;
        w_alu_ctl = c_ALU_SUB;
      end
      c_OP_JAL: begin
        w_reg_write  = 1'b1;
        w_jump       = 1'b1;
        w_result_src = 2'b10;
        w_imm        = w_imm_j;
      end
      default: ;
    endcase
  end

  // A same-cycle writeback wins over the stored value so dependent reads see the new data.
  assign w_wb_en = bus.RegWriteW && (bus.RDW != 5'd0);
  assign w_rd1 = (w_rs1 == 5'd0) ? '0 :
                 (w_wb_en && bus.RDW == w_rs1) ? bus.ResultW : r_rf[w_rs1];
  assign w_rd2 = (w_rs2 == 5'd0) ? '0 :
                 (w_wb_en && bus.RDW == w_rs2) ? bus.ResultW : r_rf[w_rs2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_rf[bus.RDW] <= bus.ResultW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.RegWriteE   <= 1'b0;
      bus.ResultSrcE  <= 2'b00;
      bus.MemWriteE   <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUControlE <= 3'b000;
      bus.ALUSrcE     <= 1'b0;
      bus.RD1E        <= '0;
      bus.RD2E        <= '0;
      bus.ImmExtE     <= '0;
      bus.RDE         <= 5'd0;
      bus.PCE         <= '0;
      bus.PCPlus4E    <= '0;
    end else begin
      bus.RegWriteE   <= w_reg_write;
      bus.ResultSrcE  <= w_result_src;
      bus.MemWriteE   <= w_mem_write;
      bus.JumpE       <= w_jump;
      bus.BranchE     <= w_branch;
      bus.ALUControlE <= w_alu_ctl;
      bus.ALUSrcE     <= w_alu_src;
      bus.RD1E        <= w_rd1;
      bus.RD2E        <= w_rd2;
      bus.ImmExtE     <= w_imm;
      bus.RDE         <= bus.InstrD[11:7];
      bus.PCE         <= bus.PCD;
      bus.PCPlus4E    <= bus.PCPlus4D;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_decode_stage_module.sv
// tb_decode_stage_module: directed literal checks plus randomized traffic against a behavioural model.
// Revision: 1.0
`default_nettype none

module tb_decode_stage_module;
  typedef struct packed {
    logic        rw;
    logic [1:0]  rsrc;
    logic        mw;
    logic        j;
    logic        b;
    logic [2:0]  alu;
    logic        asrc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
  } idex_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  decode_stage_module_if #(.XLEN(32)) bus ();

  decode_stage_module #(.REG_COUNT(32), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  idex_t w_dut;
  assign w_dut = '{bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE, bus.BranchE,
                   bus.ALUControlE, bus.ALUSrcE, bus.RD1E, bus.RD2E, bus.ImmExtE,
                   bus.RDE, bus.PCE, bus.PCPlus4E};

  logic [31:0] m_rf [32];
  idex_t       m_exp;

  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wa == idx) return wd;
    return m_rf[idx];
  endfunction

  function automatic logic [2:0] m_alu(input logic [2:0] f3, input logic allow_sub, input logic f7b5);
    case (f3)
      3'b000:  return (allow_sub && f7b5) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic idex_t m_decode(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] pc4, input logic we,
                                     input logic [4:0] wa, input logic [31:0] wd);
    idex_t e;
    int    sx;
    int    imm_i, imm_s, imm_b, imm_j;
    e = '0;
    sx    = $signed(ins) >>> 31;
    imm_i = $signed(ins) >>> 20;
    imm_s = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
    imm_b = (sx * 4096) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    imm_j = (sx * 1048576) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    e.rd1 = m_read(ins[19:15], we, wa, wd);
    e.rd2 = m_read(ins[24:20], we, wa, wd);
    e.rd  = ins[11:7];
    e.pc  = pc;
    e.pc4 = pc4;
    case (ins[6:0])
      7'b0000011: begin e.rw = 1; e.rsrc = 2'b01; e.asrc = 1; e.imm = imm_i; end
      7'b0100011: begin e.mw = 1; e.asrc = 1; e.imm = imm_s; end
      7'b0110011: begin e.rw = 1; e.alu = m_alu(ins[14:12], 1'b1, ins[30]); end
      7'b0010011: begin e.rw = 1; e.asrc = 1; e.imm = imm_i; e.alu = m_alu(ins[14:12], 1'b0, ins[30]); end
      7'b1100011: begin e.b = 1; e.alu = 3'b001; e.imm = imm_b; end
      7'b1101111: begin e.rw = 1; e.j = 1; e.rsrc = 2'b10; e.imm = imm_j; end
      default: begin e.rw = 0; e.imm = 32'd0; end
    endcase
    return e;
  endfunction

  // Model state advances at each edge; the compare happens 1 time unit later.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_exp = '0;
    end else begin
      m_exp = m_decode(bus.InstrD, bus.PCD, bus.PCPlus4D, bus.RegWriteW, bus.RDW, bus.ResultW);
      if (bus.RegWriteW && bus.RDW != 5'd0) m_rf[bus.RDW] = bus.ResultW;
    end
    cyc = cyc + 1;
    #1;
    checks = checks + 1;
    if (w_dut !== m_exp) begin
      errors = errors + 1;
      $display("FAIL idex cycle=%0d actual=%h required=%h", cyc, w_dut, m_exp);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    bus.InstrD    = ins;
    bus.PCD       = pc;
    bus.PCPlus4D  = pc + 32'd4;
    bus.RegWriteW = we;
    bus.RDW       = wa;
    bus.ResultW   = wd;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  ops [6];
    checks = 0;
    errors = 0;
    cyc    = 0;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    rst = 1'b0;
    bus.InstrD = 32'd0; bus.PCD = 32'd0; bus.PCPlus4D = 32'd0;
    bus.RegWriteW = 1'b0; bus.RDW = 5'd0; bus.ResultW = 32'd0;

    @(posedge clk); #2;
    chk("reset_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
    chk("reset_pce", bus.PCE, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    cycle(32'h00500093, 32'h10, 1'b0, 5'd0, 32'd0);
    chk("addi_regwrite", {31'd0, bus.RegWriteE}, 32'd1);
    chk("addi_alusrc", {31'd0, bus.ALUSrcE}, 32'd1);
    chk("addi_aluctl", {29'd0, bus.ALUControlE}, 32'd0);
    chk("addi_imm", bus.ImmExtE, 32'd5);
    chk("addi_rde", {27'd0, bus.RDE}, 32'd1);
    chk("addi_rd1", bus.RD1E, 32'd0);
    chk("addi_pce", bus.PCE, 32'h10);
    chk("addi_pc4", bus.PCPlus4E, 32'h14);

    cycle(32'd0, 32'h14, 1'b1, 5'd1, 32'd7);
    cycle(32'd0, 32'h18, 1'b1, 5'd2, 32'd3);
    cycle(32'h002081B3, 32'h1C, 1'b1, 5'd2, 32'd9);
    chk("add_rd1", bus.RD1E, 32'd7);
    chk("add_rd2_bypass", bus.RD2E, 32'd9);
    chk("add_aluctl", {29'd0, bus.ALUControlE}, 32'd0);
    chk("add_rde", {27'd0, bus.RDE}, 32'd3);

    cycle(32'hFFC12283, 32'h20, 1'b0, 5'd0, 32'd0);
    chk("lw_imm", bus.ImmExtE, 32'hFFFFFFFC);
    chk("lw_rsrc", {30'd0, bus.ResultSrcE}, 32'd1);
    chk("lw_regwrite", {31'd0, bus.RegWriteE}, 32'd1);
    cycle(32'h0020A423, 32'h24, 1'b0, 5'd0, 32'd0);
    chk("sw_imm", bus.ImmExtE, 32'd8);
    chk("sw_memwrite", {31'd0, bus.MemWriteE}, 32'd1);
    chk("sw_regwrite", {31'd0, bus.RegWriteE}, 32'd0);

    cycle(32'hFE208CE3, 32'h28, 1'b0, 5'd0, 32'd0);
    chk("beq_branch", {31'd0, bus.BranchE}, 32'd1);
    chk("beq_aluctl", {29'd0, bus.ALUControlE}, 32'd1);
    chk("beq_imm", bus.ImmExtE, 32'hFFFFFFF8);
    cycle(32'h010000EF, 32'h2C, 1'b0, 5'd0, 32'd0);
    chk("jal_jump", {31'd0, bus.JumpE}, 32'd1);
    chk("jal_rsrc", {30'd0, bus.ResultSrcE}, 32'd2);
    chk("jal_imm", bus.ImmExtE, 32'h10);
    chk("jal_rde", {27'd0, bus.RDE}, 32'd1);

    cycle(32'h000001B3, 32'h30, 1'b1, 5'd0, 32'hDEADBEEF);
    chk("x0_same_cycle", bus.RD1E, 32'd0);
    cycle(32'h000001B3, 32'h34, 1'b0, 5'd0, 32'd0);
    chk("x0_after_write", bus.RD1E, 32'd0);
    cycle(32'hFFFFFFFF, 32'h38, 1'b0, 5'd0, 32'd0);
    chk("illegal_ctl", {23'd0, bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE,
                        bus.BranchE, bus.ALUControlE, bus.ALUSrcE}, 32'd0);
    chk("illegal_imm", bus.ImmExtE, 32'd0);

    cycle(32'h002081B3, 32'h3C, 1'b0, 5'd0, 32'd0);
    chk("pre_reset_rd1", bus.RD1E, 32'd7);
    rst = 1'b0;
    #1;
    chk("async_rd1", bus.RD1E, 32'd0);
    chk("async_pce", bus.PCE, 32'd0);
    chk("async_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
    @(negedge clk);
    bus.InstrD = 32'd0; bus.PCD = 32'd0; bus.PCPlus4D = 32'd0; bus.RegWriteW = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle(32'h002081B3, 32'h40, 1'b0, 5'd0, 32'd0);
    chk("post_reset_rd1", bus.RD1E, 32'd0);
    chk("post_reset_rd2", bus.RD2E, 32'd0);

    for (int n = 0; n < 2000; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 5)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      cycle(ins, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    @(negedge clk);
    bus.InstrD = 32'd0; bus.RegWriteW = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
